// File: rtl/code_fetch.sv
// code_fetch: issues sequential code-line reads and buffers returned words for the decode stage.
// Define CODE_FETCH_PERF_EN to add the perf_stall_cycles backpressure counter output.

module code_fetch #(
   parameter int DATA_W     = 12,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              ctrl_active,
   input  logic              ctrl_reset,
   input  logic [ADDR_W-1:0] code_length,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_read_line,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_code,
   output logic [ADDR_W-1:0] out_code_index,
   output logic              busy,
   output logic              done
`ifdef CODE_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] last_line_reg;
   logic              pend_reg;
   logic [ADDR_W-1:0] pend_line_reg;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  occupancy;
   logic              issue, last_issue, push, pop;

   logic [DATA_W-1:0] fifo_code  [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_index [FIFO_DEPTH];

   // Reads in flight (strobe stage + return stage) reserve FIFO slots so a return never overflows.
   assign occupancy  = count_reg + CNT_W'(mem_read_en) + CNT_W'(pend_reg);
   assign issue      = (state_reg == RUN) && ctrl_active && (occupancy < CNT_W'(FIFO_DEPTH));
   assign last_issue = issue && (pc_reg == last_line_reg);
   assign push       = pend_reg;
   assign pop        = out_valid && out_ready;

   assign out_valid      = (count_reg != '0);
   assign out_code       = out_valid ? fifo_code[rd_ptr_reg]  : '0;
   assign out_code_index = out_valid ? fifo_index[rd_ptr_reg] : '0;
   assign busy           = (state_reg == RUN) || (state_reg == DRAIN);
   assign done           = (state_reg == DONE);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (ctrl_reset) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ctrl_active) begin
                  state_next = (code_length == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (last_issue) begin
                  state_next = DRAIN;
               end
            end
            DRAIN: begin
               if ((count_reg == '0) && !mem_read_en && !pend_reg) begin
                  state_next = DONE;
               end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pc_reg        <= '0;
         last_line_reg <= '0;
         mem_read_en   <= 1'b0;
         mem_read_line <= '0;
         pend_reg      <= 1'b0;
         pend_line_reg <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
      end else if (ctrl_reset) begin
         // Dropping both pipeline stages discards any word still on its way back.
         pc_reg        <= '0;
         mem_read_en   <= 1'b0;
         mem_read_line <= '0;
         pend_reg      <= 1'b0;
         pend_line_reg <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
      end else begin
         if ((state_reg == IDLE) && ctrl_active) begin
            last_line_reg <= code_length - ADDR_W'(1);
         end
         mem_read_en <= issue;
         if (issue) begin
            mem_read_line <= pc_reg;
            pc_reg        <= pc_reg + ADDR_W'(1);
         end
         pend_reg      <= mem_read_en;
         pend_line_reg <= mem_read_line;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + CNT_W'(1);
         end else if (!push && pop) begin
            count_reg <= count_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push && !ctrl_reset) begin
         fifo_code[wr_ptr_reg]  <= mem_read_data;
         fifo_index[wr_ptr_reg] <= pend_line_reg;
      end
   end

`ifdef CODE_FETCH_PERF_EN
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         perf_stall_cycles <= '0;
      end else if (ctrl_reset) begin
         perf_stall_cycles <= '0;
      end else if (out_valid && !out_ready && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
         perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule
